// File: rtl/sata_identify_decoder_if.sv
// Receive dword stream from the SATA transport layer into the IDENTIFY DEVICE decoder.
// A beat transfers on every cycle i_val is high; i_rdy is tied high, so the sink never stalls the source.
interface sata_identify_decoder_if;
    logic [31:0] i_dat;
    logic        i_val;
    logic        i_eop;
    logic        i_err;
    logic        i_rdy;

    modport master (output i_dat, output i_val, output i_eop, output i_err, input  i_rdy);
    modport slave  (input  i_dat, input  i_val, input  i_eop, input  i_err, output i_rdy);
endinterface

// File: rtl/sata_identify_decoder.sv
// Parses the 512-byte IDENTIFY DEVICE frame into shadow registers and publishes the
// capability/capacity fields atomically only when length, CRC and checksum all pass.
module sata_identify_decoder #(
    parameter int FIS_LEN         = 128,
    parameter bit VERIFY_CHECKSUM = 1'b1,
    parameter bit LBA28_FALLBACK  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    sata_identify_decoder_if.slave rx,
    input  logic                   id_clear,
    output logic                   frame_done,
    output logic                   id_valid,
    output logic [2:0]             sata_gen_supported,
    output logic                   ncq_supported,
    output logic [4:0]             queue_depth,
    output logic                   lba48_supported,
    output logic [47:0]            max_lba_address,
    output logic                   bad_crc,
    output logic                   bad_length,
    output logic                   bad_checksum
);
    localparam int             CW       = $clog2(FIS_LEN + 1);
    localparam logic [CW-1:0]  LEN_MAX  = CW'(FIS_LEN);
    localparam logic [CW-1:0]  LEN_LAST = CW'(FIS_LEN - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    sum_q, sum_d;
    logic [31:0]   lba28_q, lba28_d;
    logic [4:0]    qd_q, qd_d;
    logic [2:0]    gen_q, gen_d;
    logic          ncq_q, ncq_d;
    logic          lba48_q, lba48_d;
    logic [31:0]   lba_lo_q, lba_lo_d;
    logic [15:0]   lba_hi_q, lba_hi_d;

    logic          frame_done_q, frame_done_d;
    logic          id_valid_q, id_valid_d;
    logic [2:0]    pub_gen_q, pub_gen_d;
    logic          pub_ncq_q, pub_ncq_d;
    logic [4:0]    pub_qd_q, pub_qd_d;
    logic          pub_lba48_q, pub_lba48_d;
    logic [47:0]   pub_lba_q, pub_lba_d;
    logic          bad_crc_q, bad_crc_d;
    logic          bad_length_q, bad_length_d;
    logic          bad_checksum_q, bad_checksum_d;

    logic [7:0]    beat_sum;
    logic          eop_beat;
    logic          len_bad;
    logic          cks_bad;
    logic          good_end;
    logic [47:0]   lba_sel;
    logic [4:0]    qd_inc;

    assign rx.i_rdy   = 1'b1;
    assign beat_sum   = sum_q + rx.i_dat[7:0] + rx.i_dat[15:8] + rx.i_dat[23:16] + rx.i_dat[31:24];
    assign eop_beat   = rx.i_val & rx.i_eop;
    // An eop seen at LEN_MAX is always a length error, so the overflow flag only adds history.
    assign len_bad    = (cnt_q != LEN_LAST) | ovf_q;
    assign cks_bad    = VERIFY_CHECKSUM & ~len_bad & (rx.i_dat[23:16] == 8'hA5) & (beat_sum != 8'h00);
    assign good_end   = eop_beat & ~len_bad & ~rx.i_err & ~cks_bad;
    assign lba_sel    = (lba48_q | ~LBA28_FALLBACK) ? {lba_hi_q, lba_lo_q} : {16'h0000, lba28_q};
    assign qd_inc     = (qd_q == 5'd31) ? 5'd31 : qd_q + 5'd1;

    always_comb begin
        cnt_d          = cnt_q;
        ovf_d          = ovf_q;
        sum_d          = sum_q;
        lba28_d        = lba28_q;
        qd_d           = qd_q;
        gen_d          = gen_q;
        ncq_d          = ncq_q;
        lba48_d        = lba48_q;
        lba_lo_d       = lba_lo_q;
        lba_hi_d       = lba_hi_q;
        frame_done_d   = 1'b0;
        id_valid_d     = id_valid_q;
        pub_gen_d      = pub_gen_q;
        pub_ncq_d      = pub_ncq_q;
        pub_qd_d       = pub_qd_q;
        pub_lba48_d    = pub_lba48_q;
        pub_lba_d      = pub_lba_q;
        bad_crc_d      = bad_crc_q;
        bad_length_d   = bad_length_q;
        bad_checksum_d = bad_checksum_q;

        if (rx.i_val) begin
            if (cnt_q == CW'(30)) lba28_d = rx.i_dat;
            if (cnt_q == CW'(37)) qd_d = rx.i_dat[20:16];
            if (cnt_q == CW'(38)) begin
                gen_d = rx.i_dat[3:1];
                ncq_d = rx.i_dat[8];
            end
            if (cnt_q == CW'(41)) lba48_d = rx.i_dat[26];
            if (cnt_q == CW'(50)) lba_lo_d = rx.i_dat;
            if (cnt_q == CW'(51)) lba_hi_d = rx.i_dat[15:0];

            if (rx.i_eop) begin
                cnt_d          = '0;
                ovf_d          = 1'b0;
                sum_d          = 8'h00;
                frame_done_d   = 1'b1;
                bad_length_d   = len_bad;
                bad_crc_d      = rx.i_err;
                bad_checksum_d = cks_bad;
            end else begin
                if (cnt_q == LEN_MAX) ovf_d = 1'b1;
                else                  cnt_d = cnt_q + CW'(1);
                sum_d = beat_sum;
            end
        end

        if (id_clear) begin
            id_valid_d  = 1'b0;
            pub_gen_d   = 3'b000;
            pub_ncq_d   = 1'b0;
            pub_qd_d    = 5'd0;
            pub_lba48_d = 1'b0;
            pub_lba_d   = 48'h0;
        end

        // Publication deliberately overrides a coincident clear.
        if (good_end) begin
            id_valid_d  = 1'b1;
            pub_gen_d   = gen_q;
            pub_ncq_d   = ncq_q;
            pub_qd_d    = qd_inc;
            pub_lba48_d = lba48_q;
            pub_lba_d   = lba_sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            sum_q          <= 8'h00;
            lba28_q        <= 32'h0;
            qd_q           <= 5'd0;
            gen_q          <= 3'b000;
            ncq_q          <= 1'b0;
            lba48_q        <= 1'b0;
            lba_lo_q       <= 32'h0;
            lba_hi_q       <= 16'h0;
            frame_done_q   <= 1'b0;
            id_valid_q     <= 1'b0;
            pub_gen_q      <= 3'b000;
            pub_ncq_q      <= 1'b0;
            pub_qd_q       <= 5'd0;
            pub_lba48_q    <= 1'b0;
            pub_lba_q      <= 48'h0;
            bad_crc_q      <= 1'b0;
            bad_length_q   <= 1'b0;
            bad_checksum_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            ovf_q          <= ovf_d;
            sum_q          <= sum_d;
            lba28_q        <= lba28_d;
            qd_q           <= qd_d;
            gen_q          <= gen_d;
            ncq_q          <= ncq_d;
            lba48_q        <= lba48_d;
            lba_lo_q       <= lba_lo_d;
            lba_hi_q       <= lba_hi_d;
            frame_done_q   <= frame_done_d;
            id_valid_q     <= id_valid_d;
            pub_gen_q      <= pub_gen_d;
            pub_ncq_q      <= pub_ncq_d;
            pub_qd_q       <= pub_qd_d;
            pub_lba48_q    <= pub_lba48_d;
            pub_lba_q      <= pub_lba_d;
            bad_crc_q      <= bad_crc_d;
            bad_length_q   <= bad_length_d;
            bad_checksum_q <= bad_checksum_d;
        end
    end

    assign frame_done         = frame_done_q;
    assign id_valid           = id_valid_q;
    assign sata_gen_supported = pub_gen_q;
    assign ncq_supported      = pub_ncq_q;
    assign queue_depth        = pub_qd_q;
    assign lba48_supported    = pub_lba48_q;
    assign max_lba_address    = pub_lba_q;
    assign bad_crc            = bad_crc_q;
    assign bad_length         = bad_length_q;
    assign bad_checksum       = bad_checksum_q;
endmodule

// File: tb/tb_sata_identify_decoder.sv
// Bench for sata_identify_decoder: frame-level reference model, per-cycle output compare,
// directed scenarios with literal expectations and randomized frames with i_val gaps.
module tb_sata_identify_decoder;
    localparam int FIS_LEN         = 128;
    localparam bit VERIFY_CHECKSUM = 1'b1;
    localparam bit LBA28_FALLBACK  = 1'b1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_clear = 1'b0;
    logic        frame_done, id_valid, ncq_supported, lba48_supported;
    logic [2:0]  sata_gen_supported;
    logic [4:0]  queue_depth;
    logic [47:0] max_lba_address;
    logic        bad_crc, bad_length, bad_checksum;

    sata_identify_decoder_if rx_if ();

    sata_identify_decoder #(
        .FIS_LEN(FIS_LEN), .VERIFY_CHECKSUM(VERIFY_CHECKSUM), .LBA28_FALLBACK(LBA28_FALLBACK)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx_if.slave), .id_clear(id_clear),
        .frame_done(frame_done), .id_valid(id_valid), .sata_gen_supported(sata_gen_supported),
        .ncq_supported(ncq_supported), .queue_depth(queue_depth), .lba48_supported(lba48_supported),
        .max_lba_address(max_lba_address), .bad_crc(bad_crc), .bad_length(bad_length),
        .bad_checksum(bad_checksum)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    logic [31:0] frame_q[$];
    logic        exp_frame_done = 0, exp_id_valid = 0, exp_ncq = 0, exp_lba48 = 0;
    logic [2:0]  exp_gen = 0;
    logic [4:0]  exp_qd = 0;
    logic [47:0] exp_max_lba = 0;
    logic        exp_bad_crc = 0, exp_bad_length = 0, exp_bad_checksum = 0;

    task automatic model_frame_end(input logic err);
        int n, total;
        logic bl, bc;
        logic [7:0] sig;
        n = frame_q.size();
        total = 0;
        foreach (frame_q[k])
            total += int'(frame_q[k][7:0]) + int'(frame_q[k][15:8]) + int'(frame_q[k][23:16]) + int'(frame_q[k][31:24]);
        sig = frame_q[n-1][23:16];
        bl  = (n != FIS_LEN);
        bc  = VERIFY_CHECKSUM && !bl && (sig == 8'hA5) && ((total % 256) != 0);
        exp_frame_done   = 1'b1;
        exp_bad_length   = bl;
        exp_bad_crc      = err;
        exp_bad_checksum = bc;
        if (!bl && !err && !bc) begin
            exp_id_valid = 1'b1;
            exp_gen      = frame_q[38][3:1];
            exp_ncq      = frame_q[38][8];
            exp_qd       = (frame_q[37][20:16] == 5'd31) ? 5'd31 : frame_q[37][20:16] + 5'd1;
            exp_lba48    = frame_q[41][26];
            if (frame_q[41][26] || !LBA28_FALLBACK) exp_max_lba = {frame_q[51][15:0], frame_q[50]};
            else                                    exp_max_lba = {16'h0, frame_q[30]};
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q.delete();
            exp_frame_done = 0; exp_id_valid = 0; exp_gen = 0; exp_ncq = 0; exp_qd = 0;
            exp_lba48 = 0; exp_max_lba = 0; exp_bad_crc = 0; exp_bad_length = 0; exp_bad_checksum = 0;
        end else begin
            exp_frame_done = 1'b0;
            if (id_clear) begin
                exp_id_valid = 0; exp_gen = 0; exp_ncq = 0; exp_qd = 0; exp_lba48 = 0; exp_max_lba = 0;
            end
            if (rx_if.i_val) begin
                frame_q.push_back(rx_if.i_dat);
                if (rx_if.i_eop) begin
                    model_frame_end(rx_if.i_err);
                    frame_q.delete();
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("i_rdy", rx_if.i_rdy, 1'b1);
            check("frame_done", frame_done, exp_frame_done);
            check("id_valid", id_valid, exp_id_valid);
            check("gen", sata_gen_supported, exp_gen);
            check("ncq", ncq_supported, exp_ncq);
            check("queue_depth", queue_depth, exp_qd);
            check("lba48", lba48_supported, exp_lba48);
            check("max_lba", max_lba_address, exp_max_lba);
            check("bad_crc", bad_crc, exp_bad_crc);
            check("bad_length", bad_length, exp_bad_length);
            check("bad_checksum", bad_checksum, exp_bad_checksum);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] frame_buf[0:299];

    task automatic set_checksum(input int len, input logic [7:0] sig);
        int total = 0;
        frame_buf[len-1][23:16] = sig;
        frame_buf[len-1][31:24] = 8'h00;
        for (int k = 0; k < len; k++)
            total += int'(frame_buf[k][7:0]) + int'(frame_buf[k][15:8]) + int'(frame_buf[k][23:16]) + int'(frame_buf[k][31:24]);
        frame_buf[len-1][31:24] = 8'((256 - (total % 256)) % 256);
    endtask

    task automatic make_frame();
        for (int k = 0; k < 300; k++) frame_buf[k] = $urandom;
        frame_buf[37] = 32'h001F_0000;
        frame_buf[38] = 32'h0000_010E;
        frame_buf[41] = $urandom | 32'h0400_0000;
        frame_buf[50] = 32'h1234_5678;
        frame_buf[51] = 32'h0000_9ABC;
        set_checksum(FIS_LEN, 8'hA5);
    endtask

    task automatic idle_cycle();
        rx_if.i_val = 1'b0;
        rx_if.i_dat = $urandom;
        rx_if.i_eop = 1'($urandom_range(0, 1));
        rx_if.i_err = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int len, input bit err, input int max_gap, input bit clr_eop, input int abort_at);
        for (int i = 0; i < len; i++) begin
            if (i == abort_at) begin
                rx_if.i_val = 1'b0;
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) idle_cycle();
            rx_if.i_val = 1'b1;
            rx_if.i_dat = frame_buf[i];
            rx_if.i_eop = (i == len - 1);
            rx_if.i_err = (i == len - 1) ? err : 1'($urandom_range(0, 1));
            id_clear    = clr_eop && (i == len - 1);
            @(posedge clk); #1;
        end
        rx_if.i_val = 1'b0;
        rx_if.i_eop = 1'b0;
        rx_if.i_err = 1'b0;
        id_clear    = 1'b0;
    endtask

    task automatic pulse_clear();
        id_clear = 1'b1;
        @(posedge clk); #1;
        id_clear = 1'b0;
    endtask

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int len, r;
        rx_if.i_val = 1'b0; rx_if.i_dat = '0; rx_if.i_eop = 1'b0; rx_if.i_err = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_id_valid", id_valid, 1'b0);
        check("reset_max_lba", max_lba_address, 48'h0);

        // Good frame with LBA48
        make_frame();
        send_frame(FIS_LEN, 1'b0, 0, 1'b0, -1);
        check("good_frame_done", frame_done, 1'b1);
        check("good_id_valid", id_valid, 1'b1);
        check("good_gen", sata_gen_supported, 3'b111);
        check("good_ncq", ncq_supported, 1'b1);
        check("good_qd_sat", queue_depth, 5'd31);
        check("good_lba48", lba48_supported, 1'b1);
        check("good_max_lba", max_lba_address, 48'h9ABC_1234_5678);
        check("good_bad_flags", {bad_crc, bad_length, bad_checksum}, 3'b000);
        @(posedge clk); #1;
        check("frame_done_one_cycle", frame_done, 1'b0);

        // LBA28 fallback
        frame_buf[41] = frame_buf[41] & ~32'h0400_0000;
        frame_buf[30] = 32'h0EE7_C2B0;
        set_checksum(FIS_LEN, 8'hA5);
        send_frame(FIS_LEN, 1'b0, 0, 1'b0, -1);
        check("lba28_max_lba", max_lba_address, 48'h0000_0EE7_C2B0);
        check("lba28_lba48", lba48_supported, 1'b0);

        // Checksum corruption, then the same corruption without signature
        frame_buf[10] = frame_buf[10] ^ 32'h0000_0008;
        send_frame(FIS_LEN, 1'b0, 0, 1'b0, -1);
        check("cks_bad_checksum", bad_checksum, 1'b1);
        check("cks_hold_valid", id_valid, 1'b1);
        check("cks_hold_lba", max_lba_address, 48'h0000_0EE7_C2B0);
        frame_buf[30] = 32'h1111_2222;
        frame_buf[FIS_LEN-1][23:16] = 8'h00;
        send_frame(FIS_LEN, 1'b0, 0, 1'b0, -1);
        check("nosig_bad_checksum", bad_checksum, 1'b0);
        check("nosig_published", max_lba_address, 48'h0000_1111_2222);

        // Length errors
        make_frame();
        send_frame(100, 1'b0, 0, 1'b0, -1);
        check("short_bad_length", bad_length, 1'b1);
        check("short_hold_lba", max_lba_address, 48'h0000_1111_2222);
        send_frame(130, 1'b0, 0, 1'b0, -1);
        check("long_bad_length", bad_length, 1'b1);
        check("long_hold_lba", max_lba_address, 48'h0000_1111_2222);
        send_frame(1, 1'b0, 0, 1'b0, -1);
        check("single_bad_length", bad_length, 1'b1);

        // CRC error then clean frame
        send_frame(FIS_LEN, 1'b1, 0, 1'b0, -1);
        check("crc_bad_crc", bad_crc, 1'b1);
        check("crc_bad_length", bad_length, 1'b0);
        check("crc_hold_lba", max_lba_address, 48'h0000_1111_2222);
        send_frame(FIS_LEN, 1'b0, 0, 1'b0, -1);
        check("clean_bad_crc", bad_crc, 1'b0);
        check("clean_max_lba", max_lba_address, 48'h9ABC_1234_5678);

        // Gaps, clear, reset mid-frame
        send_frame(FIS_LEN, 1'b0, 5, 1'b0, -1);
        check("gap_max_lba", max_lba_address, 48'h9ABC_1234_5678);
        pulse_clear();
        check("clear_id_valid", id_valid, 1'b0);
        check("clear_max_lba", max_lba_address, 48'h0);
        send_frame(FIS_LEN, 1'b0, 0, 1'b0, 60);
        send_frame(FIS_LEN, 1'b0, 0, 1'b0, -1);
        check("post_reset_valid", id_valid, 1'b1);
        check("post_reset_lba", max_lba_address, 48'h9ABC_1234_5678);
        frame_buf[50] = 32'hCAFE_F00D;
        set_checksum(FIS_LEN, 8'hA5);
        send_frame(FIS_LEN, 1'b0, 0, 1'b1, -1);
        check("clear_eop_valid", id_valid, 1'b1);
        check("clear_eop_lba", max_lba_address, 48'h9ABC_CAFE_F00D);

        // Randomized frames against the model
        for (int f = 0; f < 16; f++) begin
            for (int k = 0; k < 300; k++) frame_buf[k] = $urandom;
            r = $urandom_range(0, 9);
            len = (r < 7) ? FIS_LEN : $urandom_range(64, 140);
            r = $urandom_range(0, 3);
            if (r < 2)       set_checksum(len, 8'hA5);
            else if (r == 2) frame_buf[len-1][23:16] = 8'hA5;
            send_frame(len, ($urandom_range(0, 6) == 0), 5, ($urandom_range(0, 4) == 0), -1);
            if ($urandom_range(0, 3) == 0) pulse_clear();
            repeat ($urandom_range(0, 3)) idle_cycle();
        end

        repeat (4) idle_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
